// File: rtl/of_exact_matcher_pkg.sv
// Shared types and constants for the OpenFlow exact-match lookup stage.
// Optional wildcard matching is enabled by defining OF_MATCH_WILDCARD_EN.
`ifndef OF_ACTION_DATA_WIDTH
`define OF_ACTION_DATA_WIDTH 32
`endif
`ifndef OF_ACTION_CTRL_WIDTH
`define OF_ACTION_CTRL_WIDTH 8
`endif

package of_exact_matcher_pkg;

   localparam int CNT_WIDTH  = 32;
   localparam int ACT_DATA_W = `OF_ACTION_DATA_WIDTH;
   localparam int ACT_CTRL_W = `OF_ACTION_CTRL_WIDTH;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SEARCH = 2'd1;
   localparam logic [1:0] ST_RESULT = 2'd2;

   typedef struct packed {
      logic [ACT_DATA_W-1:0] data;
      logic [ACT_CTRL_W-1:0] ctrl;
   } action_t;

   // A miss reports an all-zero action.
   localparam action_t MISS_ACTION = '{data: {ACT_DATA_W{1'b0}}, ctrl: {ACT_CTRL_W{1'b0}}};

endpackage

// File: rtl/of_match_table.sv
// Register-based flow table: one write port, one combinational read/compare port.
// OF_MATCH_WILDCARD_EN adds a per-entry care-bit mask to the compare.
module of_match_table
   import of_exact_matcher_pkg::*;
#(
   parameter int KEY_W = 64,
   parameter int N     = 8,
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic             wr_valid,
   input  logic [KEY_W-1:0] wr_key,
   input  logic [KEY_W-1:0] wr_mask,
   input  action_t          wr_action,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic [KEY_W-1:0] rd_key,
   output logic             rd_match,
   output action_t          rd_action
);

   logic    [N-1:0]     valid_q, valid_d;
   logic    [KEY_W-1:0] key_q [N];
   logic    [KEY_W-1:0] key_d [N];
   action_t             act_q [N];
   action_t             act_d [N];

   // Next-state of every entry: only the addressed entry takes the write.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         valid_d[i] = (wr_en && (wr_addr == IDX_W'(i))) ? wr_valid  : valid_q[i];
         key_d[i]   = (wr_en && (wr_addr == IDX_W'(i))) ? wr_key    : key_q[i];
         act_d[i]   = (wr_en && (wr_addr == IDX_W'(i))) ? wr_action : act_q[i];
      end
   end

   // Valid bits are the only table state cleared by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= {N{1'b0}};
      end else begin
         valid_q <= valid_d;
      end
   end

   // Key and action storage; contents behind a cleared valid bit are don't-care.
   always_ff @(posedge clk) begin
      key_q <= key_d;
      act_q <= act_d;
   end

   assign rd_action = act_q[rd_idx];

`ifdef OF_MATCH_WILDCARD_EN
   logic [KEY_W-1:0] mask_q [N];
   logic [KEY_W-1:0] mask_d [N];

   // Mask storage follows the same write rule as the keys.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         mask_d[i] = (wr_en && (wr_addr == IDX_W'(i))) ? wr_mask : mask_q[i];
      end
   end

   // Mask registers.
   always_ff @(posedge clk) begin
      mask_q <= mask_d;
   end

   assign rd_match = valid_q[rd_idx] &&
                     (((key_q[rd_idx] ^ rd_key) & mask_q[rd_idx]) == {KEY_W{1'b0}});
`else
   logic unused_mask_s;
   assign unused_mask_s = ^wr_mask;
   assign rd_match      = valid_q[rd_idx] && (key_q[rd_idx] == rd_key);
`endif

endmodule

// File: rtl/of_exact_matcher.sv
// Flow-table lookup: sequential search, one entry per cycle, one action result per key.
// Define OF_MATCH_WILDCARD_EN to enable masked (wildcard) matching in the table.
module of_exact_matcher
   import of_exact_matcher_pkg::*;
#(
   parameter int FLOW_KEY_WIDTH = 64,
   parameter int NUM_ENTRIES    = 8,
   parameter int IDX_WIDTH      = $clog2(NUM_ENTRIES)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [FLOW_KEY_WIDTH-1:0]        key,
   input  logic                             key_valid,
   output logic                             key_rdy,
   input  logic                             tbl_wr_en,
   input  logic [IDX_WIDTH-1:0]             tbl_wr_addr,
   input  logic                             tbl_wr_entry_valid,
   input  logic [FLOW_KEY_WIDTH-1:0]        tbl_wr_key,
   input  logic [FLOW_KEY_WIDTH-1:0]        tbl_wr_mask,
   input  logic [`OF_ACTION_DATA_WIDTH-1:0] tbl_wr_action_data,
   input  logic [`OF_ACTION_CTRL_WIDTH-1:0] tbl_wr_action_ctrl,
   output logic [`OF_ACTION_DATA_WIDTH-1:0] action_data_bus,
   output logic [`OF_ACTION_CTRL_WIDTH-1:0] action_ctrl_bus,
   output logic                             action_valid,
   output logic                             action_hit,
   output logic [CNT_WIDTH-1:0]             hit_count,
   output logic [CNT_WIDTH-1:0]             miss_count
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ENTRIES - 1);

   logic [1:0]                state_q, state_d;
   logic [IDX_WIDTH-1:0]      idx_q, idx_d;
   logic [FLOW_KEY_WIDTH-1:0] key_q, key_d;
   action_t                   act_q, act_d;
   logic                      hit_q, hit_d;
   logic                      valid_q, valid_d;
   logic                      key_rdy_q, key_rdy_d;
   logic [CNT_WIDTH-1:0]      hit_count_q, hit_count_d;
   logic [CNT_WIDTH-1:0]      miss_count_q, miss_count_d;
   action_t                   wr_action_s;
   action_t                   rd_action_s;
   logic                      match_s;

   assign wr_action_s = '{data: tbl_wr_action_data, ctrl: tbl_wr_action_ctrl};

   of_match_table #(
      .KEY_W (FLOW_KEY_WIDTH),
      .N     (NUM_ENTRIES),
      .IDX_W (IDX_WIDTH)
   ) u_table (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (tbl_wr_en),
      .wr_addr   (tbl_wr_addr),
      .wr_valid  (tbl_wr_entry_valid),
      .wr_key    (tbl_wr_key),
      .wr_mask   (tbl_wr_mask),
      .wr_action (wr_action_s),
      .rd_idx    (idx_q),
      .rd_key    (key_q),
      .rd_match  (match_s),
      .rd_action (rd_action_s)
   );

   // Search FSM; result registers default to zero so the buses idle low outside RESULT.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      key_d        = key_q;
      act_d        = MISS_ACTION;
      hit_d        = 1'b0;
      valid_d      = 1'b0;
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      case (state_q)
         ST_IDLE: begin
            if (key_valid && key_rdy_q) begin
               key_d   = key;
               idx_d   = {IDX_WIDTH{1'b0}};
               state_d = ST_SEARCH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEARCH: begin
            if (match_s) begin
               act_d       = rd_action_s;
               hit_d       = 1'b1;
               valid_d     = 1'b1;
               hit_count_d = hit_count_q + 32'd1;
               state_d     = ST_RESULT;
            end else if (idx_q == LAST_IDX) begin
               valid_d      = 1'b1;
               miss_count_d = miss_count_q + 32'd1;
               state_d      = ST_RESULT;
            end else begin
               idx_d = idx_q + IDX_WIDTH'(1);
            end
         end
         ST_RESULT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      key_rdy_d = (state_d == ST_IDLE);
   end

   // Control, result and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= {IDX_WIDTH{1'b0}};
         key_q        <= {FLOW_KEY_WIDTH{1'b0}};
         act_q        <= MISS_ACTION;
         hit_q        <= 1'b0;
         valid_q      <= 1'b0;
         key_rdy_q    <= 1'b0;
         hit_count_q  <= {CNT_WIDTH{1'b0}};
         miss_count_q <= {CNT_WIDTH{1'b0}};
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         key_q        <= key_d;
         act_q        <= act_d;
         hit_q        <= hit_d;
         valid_q      <= valid_d;
         key_rdy_q    <= key_rdy_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign key_rdy         = key_rdy_q;
   assign action_valid    = valid_q;
   assign action_hit      = hit_q;
   assign action_data_bus = act_q.data;
   assign action_ctrl_bus = act_q.ctrl;
   assign hit_count       = hit_count_q;
   assign miss_count      = miss_count_q;

endmodule

// File: tb/tb_of_exact_matcher.sv
// Directed self-checking bench for of_exact_matcher (latency, priority, deletes, reset, wrap).
// Wildcard expectations follow OF_MATCH_WILDCARD_EN.
module tb_of_exact_matcher;
   import of_exact_matcher_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] key;
   logic        key_valid;
   logic        key_rdy;
   logic        tbl_wr_en;
   logic [2:0]  tbl_wr_addr;
   logic        tbl_wr_entry_valid;
   logic [63:0] tbl_wr_key;
   logic [63:0] tbl_wr_mask;
   logic [`OF_ACTION_DATA_WIDTH-1:0] tbl_wr_action_data;
   logic [`OF_ACTION_CTRL_WIDTH-1:0] tbl_wr_action_ctrl;
   logic [`OF_ACTION_DATA_WIDTH-1:0] action_data_bus;
   logic [`OF_ACTION_CTRL_WIDTH-1:0] action_ctrl_bus;
   logic        action_valid;
   logic        action_hit;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] K3   = 64'h0000_1111_2222_3333;
   localparam logic [63:0] K2   = 64'h5555_AAAA_0F0F_F0F0;
   localparam logic [63:0] K6   = 64'h6666_6666_6666_6666;
   localparam logic [63:0] K7   = 64'h7777_0000_0000_7777;
   localparam logic [63:0] K1   = 64'h1111_0000_2222_0000;
   localparam logic [63:0] KW   = 64'hABCD_0000_0000_0000;
   localparam logic [63:0] QW   = 64'hABCD_1234_5678_9ABC;

   of_exact_matcher dut (
      .clk                (clk),
      .reset              (reset),
      .key                (key),
      .key_valid          (key_valid),
      .key_rdy            (key_rdy),
      .tbl_wr_en          (tbl_wr_en),
      .tbl_wr_addr        (tbl_wr_addr),
      .tbl_wr_entry_valid (tbl_wr_entry_valid),
      .tbl_wr_key         (tbl_wr_key),
      .tbl_wr_mask        (tbl_wr_mask),
      .tbl_wr_action_data (tbl_wr_action_data),
      .tbl_wr_action_ctrl (tbl_wr_action_ctrl),
      .action_data_bus    (action_data_bus),
      .action_ctrl_bus    (action_ctrl_bus),
      .action_valid       (action_valid),
      .action_hit         (action_hit),
      .hit_count          (hit_count),
      .miss_count         (miss_count)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tbl_write(input logic [2:0] a, input logic v, input logic [63:0] k,
                            input logic [63:0] m, input logic [31:0] d, input logic [7:0] c);
      @(negedge clk);
      tbl_wr_en = 1'b1; tbl_wr_addr = a; tbl_wr_entry_valid = v;
      tbl_wr_key = k; tbl_wr_mask = m; tbl_wr_action_data = d; tbl_wr_action_ctrl = c;
      @(negedge clk);
      tbl_wr_en = 1'b0;
   endtask

   // Sends one key (accepted on cycle T) and samples each following cycle T+c at the negedge.
   // evt_kind 1: delete entry 6 during cycle T+evt_cycle; 2: pulse reset during that cycle.
   // exp_lat 0 means no action_valid is expected at all.
   task automatic run_key(input string tag, input logic [63:0] k, input int exp_lat,
                          input logic exp_hit, input logic [31:0] exp_data, input logic [7:0] exp_ctrl,
                          input int evt_cycle, input int evt_kind);
      int got_lat;
      got_lat = 0;
      @(negedge clk);
      check_val({tag, "_rdy_before"}, key_rdy, 1'b1);
      key = k; key_valid = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         key_valid = 1'b0;
         tbl_wr_en = 1'b0;
         reset     = 1'b0;
         if (c == evt_cycle && evt_kind == 1) begin
            tbl_wr_en = 1'b1; tbl_wr_addr = 3'd6; tbl_wr_entry_valid = 1'b0;
            tbl_wr_key = K6; tbl_wr_mask = ONES;
         end
         if (c == evt_cycle && evt_kind == 2) reset = 1'b1;
         if (got_lat != 0 && c == got_lat + 1) begin
            check_val({tag, "_valid_1cyc"}, action_valid, 1'b0);
            check_val({tag, "_rdy_after"}, key_rdy, 1'b1);
            check_val({tag, "_idle_bus"}, {action_hit, action_ctrl_bus, action_data_bus}, 64'd0);
            break;
         end
         if (action_valid && got_lat == 0) begin
            got_lat = c;
            check_val({tag, "_hit"}, action_hit, exp_hit);
            check_val({tag, "_data"}, action_data_bus, exp_data);
            check_val({tag, "_ctrl"}, action_ctrl_bus, exp_ctrl);
            check_val({tag, "_rdy_during"}, key_rdy, 1'b0);
         end
      end
      check_val({tag, "_latency"}, got_lat, exp_lat);
   endtask

   initial begin
      reset = 1'b1; key = 64'd0; key_valid = 1'b0; tbl_wr_en = 1'b0; tbl_wr_addr = 3'd0;
      tbl_wr_entry_valid = 1'b0; tbl_wr_key = 64'd0; tbl_wr_mask = 64'd0;
      tbl_wr_action_data = '0; tbl_wr_action_ctrl = '0;
      repeat (3) @(negedge clk);
      check_val("rst_key_rdy", key_rdy, 1'b0);
      check_val("rst_valid", action_valid, 1'b0);
      check_val("rst_bus", {action_hit, action_ctrl_bus, action_data_bus}, 64'd0);
      check_val("rst_counts", {hit_count, miss_count}, 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check_val("rst_release_rdy", key_rdy, 1'b1);

      run_key("empty_miss", K3, 9, 1'b0, 32'd0, 8'd0, 0, 0);
      check_val("empty_counts", {hit_count, miss_count}, {32'd0, 32'd1});

      tbl_write(3'd3, 1'b1, K3, ONES, 32'hDEAD_BEEF, 8'h01);
      tbl_write(3'd2, 1'b1, K2, ONES, 32'h0000_2222, 8'h01);
      tbl_write(3'd5, 1'b1, K2, ONES, 32'h0000_5555, 8'h07);
      tbl_write(3'd6, 1'b1, K6, ONES, 32'h6000_0006, 8'h06);
      tbl_write(3'd7, 1'b1, K7, ONES, 32'h7000_0007, 8'h17);

      run_key("hit_e3", K3, 5, 1'b1, 32'hDEAD_BEEF, 8'h01, 0, 0);
      check_val("hit_e3_counts", {hit_count, miss_count}, {32'd1, 32'd1});
      run_key("prio_e2", K2, 4, 1'b1, 32'h0000_2222, 8'h01, 0, 0);
      run_key("hit_e6", K6, 8, 1'b1, 32'h6000_0006, 8'h06, 0, 0);
      run_key("del_e6", K6, 9, 1'b0, 32'd0, 8'd0, 3, 1);
      check_val("del_counts", {hit_count, miss_count}, {32'd3, 32'd2});
      run_key("hit_e7", K7, 9, 1'b1, 32'h7000_0007, 8'h17, 0, 0);
      run_key("near_miss", K3 ^ 64'd1, 9, 1'b0, 32'd0, 8'd0, 0, 0);
      check_val("mid_counts", {hit_count, miss_count}, {32'd4, 32'd3});

      run_key("rst_search", K3, 0, 1'b0, 32'd0, 8'd0, 3, 2);
      check_val("rst_search_rdy", key_rdy, 1'b1);
      check_val("rst_search_counts", {hit_count, miss_count}, 64'd0);
      run_key("post_rst_miss", K3, 9, 1'b0, 32'd0, 8'd0, 0, 0);

      tbl_write(3'd0, 1'b1, KW, 64'hFFFF_0000_0000_0000, 32'hA0A0_0000, 8'h0A);
`ifdef OF_MATCH_WILDCARD_EN
      run_key("wild_hit", QW, 2, 1'b1, 32'hA0A0_0000, 8'h0A, 0, 0);
      check_val("wild_counts", {hit_count, miss_count}, {32'd1, 32'd1});
`else
      run_key("mask_ignored", QW, 9, 1'b0, 32'd0, 8'd0, 0, 0);
      check_val("mask_counts", {hit_count, miss_count}, {32'd0, 32'd2});
`endif

      tbl_write(3'd1, 1'b1, K1, ONES, 32'h1111_1111, 8'h11);
      @(negedge clk);
      force dut.hit_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.hit_count_q;
      run_key("wrap_hit", K1, 3, 1'b1, 32'h1111_1111, 8'h11, 0, 0);
      check_val("wrap_count", hit_count, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/of_exact_matcher.md
Name: of_exact_matcher

Overview:
- Flow-table lookup stage directly upstream of the OpenFlow action processor.
- Accepts one flow key per packet from the header parser and searches a small register-programmed table, one entry per cycle.
- Emits exactly one action result per key on the action bus: action_valid pulse, hit flag, action data and ctrl.
- Keeps 32-bit hit and miss counters.

Parameters:
- FLOW_KEY_WIDTH, 64, width of the flow key and the stored match keys.
- NUM_ENTRIES, 8, table depth; must be a power of two, at least 2.
- IDX_WIDTH, log2(NUM_ENTRIES), width of the entry index and write address.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- key  in  FLOW_KEY_WIDTH  flow key from the parser.
- key_valid  in  1  key present.
- key_rdy  out  1  matcher can accept a key.
- tbl_wr_en  in  1  write one table entry.
- tbl_wr_addr  in  IDX_WIDTH  entry index to write.
- tbl_wr_entry_valid  in  1  entry valid bit; 0 deletes the entry.
- tbl_wr_key  in  FLOW_KEY_WIDTH  match key.
- tbl_wr_mask  in  FLOW_KEY_WIDTH  care-bit mask; used only with the optional feature.
- tbl_wr_action_data  in  `OF_ACTION_DATA_WIDTH  action data for the entry.
- tbl_wr_action_ctrl  in  `OF_ACTION_CTRL_WIDTH  action ctrl for the entry.
- action_data_bus  out  `OF_ACTION_DATA_WIDTH  result action data.
- action_ctrl_bus  out  `OF_ACTION_CTRL_WIDTH  result action ctrl.
- action_valid  out  1  one-cycle result strobe.
- action_hit  out  1  result came from a table hit.
- hit_count  out  32  number of hits.
- miss_count  out  32  number of misses.

Behaviour:
- Reset (asynchronous, active-high, clk domain):
  - state goes to IDLE.
  - All outputs are 0 except key_rdy, which is 0 during reset and 1 in the first IDLE cycle after it.
  - All entry valid bits are cleared; key, action and mask contents are don't-care.
  - Reset mid-search abandons the search and produces no action_valid.
- FSM states: IDLE, SEARCH, RESULT.
- IDLE:
  - key_rdy = 1.
  - On key_valid && key_rdy: register the key, set idx = 0, go to SEARCH.
- SEARCH:
  - key_rdy = 0.
  - Each cycle compare entry[idx]: match = valid && (stored_key == key).
  - On match: latch that entry's action data and ctrl, set hit = 1, go to RESULT.
  - On no match with idx == NUM_ENTRIES-1: latch data = 0, ctrl = 0, hit = 0, go to RESULT.
  - Otherwise idx increments.
  - Priority: lowest-index match wins.
- RESULT:
  - action_valid = 1 for exactly one cycle; action_hit and the buses hold the latched values.
  - hit_count or miss_count increments by 1; 32-bit counters wrap 0xFFFFFFFF -> 0.
  - Next state is IDLE; key_rdy rises the cycle after action_valid.
  - Outside RESULT, action_valid = 0 and the buses/hit are driven to 0.
- Latency:
  - Accept on cycle T; hit at entry k gives action_valid on cycle T+k+2.
  - A miss gives action_valid on cycle T+NUM_ENTRIES+1.
  - Minimum key-to-key spacing is 3 cycles.
- Table writes:
  - Accepted in any state; contents update on the next edge.
  - A write during SEARCH affects only comparisons in later cycles; entries already passed are not re-checked.
  - A write to entry[idx] in the same cycle it is compared uses the old contents.
- Backpressure:
  - None on the action side; one result per accepted key.
  - The consumer's action FIFO (depth 4) absorbs results. The parser guarantees at most one key per packet, and the consumer drains one result per packet.

Optional Feature:
- Macro: OF_MATCH_WILDCARD_EN.
- Defined:
  - Each entry stores tbl_wr_mask.
  - match = valid && ((stored_key ^ key) & mask) == 0.
  - An all-zero mask matches any key.
- Undefined:
  - No mask storage; tbl_wr_mask is ignored.
  - Exact match only.

Decomposition:
- Shared package/defines:
  - FSM state encodings.
  - Counter width (32).
  - Miss-action default (data 0, ctrl 0).
  - Reuse of the existing `OF_ACTION_DATA_WIDTH / `OF_ACTION_CTRL_WIDTH defines.
- One sub-module: of_match_table.
  - Register array holding valid/key/mask/action.
  - One write port, one combinational read port indexed by idx.
  - Exposes a match output for the key on its input.

Test Plan:
- Reset, then a key with the table empty -> action_valid at T+9, hit = 0, data/ctrl = 0, miss_count = 1.
- Entry 3 = {key 0x0000_1111_2222_3333, ctrl 0x01}, same key sent -> action_valid at T+5, hit = 1, ctrl = 0x01, hit_count = 1.
- Entries 2 and 5 hold the same key with ctrl 0x01 and 0x07 -> result ctrl 0x01 at T+4.
- Entry 6 is deleted (entry_valid = 0) on cycle T+3 of a search for its key -> miss at T+9.
- Reset asserted at T+3 of a search -> no action_valid; key_rdy = 1 after release; valid bits cleared, so a previously stored key now misses.
- With OF_MATCH_WILDCARD_EN, entry 0 has mask 0xFFFF_0000_0000_0000 and key 0xABCD_xxxx; key 0xABCD_1234_5678_9ABC -> hit at T+2.
- hit_count preloaded near 0xFFFFFFFF (force) plus one hit -> wraps to 0.
